// File: rtl/priority_encoder_queue_pkg.sv
// Shared types and constants for the priority encoder queue.
// Holds the index-width derivation and the output-stage state encoding.
package priority_encoder_queue_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Index width with a floor of one bit so N=1-style corner widths stay legal.
    function automatic int clog2_min1(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/priority_encoder_queue_if.sv
// Request/consumer bundle for the priority encoder queue.
// The master side issues requests and backpressure; the slave side is the queue.
interface priority_encoder_queue_if
    import priority_encoder_queue_pkg::*;
#(
    parameter int N = 8,
    localparam int W = clog2_min1(N)
) ();

    logic [N-1:0] req_i;
    logic         clear_i;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [W:0]   pend_cnt;
    logic         ovf_o;

    modport master (
        output req_i,
        output clear_i,
        output out_ready,
        input  out_valid,
        input  out_idx,
        input  pend_cnt,
        input  ovf_o
    );

    modport slave (
        input  req_i,
        input  clear_i,
        input  out_ready,
        output out_valid,
        output out_idx,
        output pend_cnt,
        output ovf_o
    );

endinterface

// File: rtl/priority_encoder_queue_prio_pick.sv
// Combinational priority pick: winning index, its one-hot mask and an any-set flag.
// MSB_FIRST=1 favours the highest set bit, 0 favours the lowest.
module prio_pick
    import priority_encoder_queue_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1,
    localparam int W        = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] index,
    output logic [N-1:0] mask,
    output logic         any
);

    // Scan toward the preferred end so the last hit seen is the winner.
    always_comb begin
        index = '0;
        for (int i = 0; i < N; i++) begin
            index = req[(MSB_FIRST != 0) ? i : (N - 1 - i)]
                  ? W'((MSB_FIRST != 0) ? i : (N - 1 - i))
                  : index;
        end
        any  = |req;
        mask = any ? ({{(N-1){1'b0}}, 1'b1} << index) : '0;
    end

endmodule

// File: rtl/priority_encoder_queue.sv
// Pending-request register feeding a one-entry output stage through a priority pick.
// Tracks a registered popcount of pending lines and a sticky duplicate-request flag.
module priority_encoder_queue
    import priority_encoder_queue_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 1,
    localparam int W        = clog2_min1(N)
) (
    input logic                     clk,
    input logic                     rst,
    priority_encoder_queue_if.slave bus
);

    logic [N-1:0] pend_r;
    logic [N-1:0] pend_next_s;
    logic [N-1:0] load_mask_s;
    logic [N-1:0] dup_s;
    logic [N-1:0] pick_mask_s;
    logic [W-1:0] pick_idx_s;
    logic         pick_any_s;
    logic         can_load_s;
    logic         load_s;
    logic [W:0]   cnt_next_s;
    logic [W:0]   cnt_r;
    logic [W-1:0] out_idx_r;
    logic         ovf_r;
    out_state_e   state_r;

    prio_pick #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_pick (
        .req   (pend_r),
        .index (pick_idx_s),
        .mask  (pick_mask_s),
        .any   (pick_any_s)
    );

    // Next pending state; a request on the line being served keeps its bit set.
    always_comb begin
        can_load_s  = (state_r == EMPTY) || bus.out_ready;
        load_s      = can_load_s && pick_any_s;
        load_mask_s = load_s ? pick_mask_s : '0;
        pend_next_s = (pend_r & ~load_mask_s) | bus.req_i;
        dup_s       = bus.req_i & pend_r & ~load_mask_s;
        cnt_next_s  = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next_s = cnt_next_s + {{W{1'b0}}, pend_next_s[i]};
        end
    end

    // Pending register, its popcount and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_r <= '0;
            cnt_r  <= '0;
            ovf_r  <= 1'b0;
        end else if (bus.clear_i) begin
            pend_r <= '0;
            cnt_r  <= '0;
            ovf_r  <= 1'b0;
        end else begin
            pend_r <= pend_next_s;
            cnt_r  <= cnt_next_s;
            ovf_r  <= ovf_r | (|dup_s);
        end
    end

    // Output-stage FSM: a held index is never displaced until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= EMPTY;
            out_idx_r <= '0;
        end else if (bus.clear_i) begin
            state_r   <= EMPTY;
            out_idx_r <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (load_s) begin
                        state_r   <= FULL;
                        out_idx_r <= pick_idx_s;
                    end else begin
                        state_r   <= EMPTY;
                        out_idx_r <= out_idx_r;
                    end
                end
                FULL: begin
                    if (!bus.out_ready) begin
                        state_r   <= FULL;
                        out_idx_r <= out_idx_r;
                    end else if (load_s) begin
                        state_r   <= FULL;
                        out_idx_r <= pick_idx_s;
                    end else begin
                        state_r   <= EMPTY;
                        out_idx_r <= out_idx_r;
                    end
                end
                default: begin
                    state_r   <= EMPTY;
                    out_idx_r <= '0;
                end
            endcase
        end
    end

    assign bus.out_valid = (state_r == FULL);
    assign bus.out_idx   = out_idx_r;
    assign bus.pend_cnt  = cnt_r;
    assign bus.ovf_o     = ovf_r;

endmodule

// File: doc/priority_encoder_queue.md
PRIORITY_ENCODER_QUEUE -- requirements
Module: priority_encoder_queue

Interface
REQ-001 Parameter N, default 8: number of request lines; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1: 1 = highest index wins; 0 = lowest index wins.
REQ-003 Derived constant W = max(1, clog2(N)): index width. It is not user-overridable.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_i  input  N  request pulses; a bit high in any cycle registers one request for that line.
REQ-007 clear_i  input  1  synchronous flush of pending requests, output stage and overflow flag.
REQ-008 out_ready  input  1  consumer accepts out_idx when out_ready and out_valid are both high.
REQ-009 out_valid  output  1  out_idx holds a served request.
REQ-010 out_idx  output  W  encoded index of the served line.
REQ-011 pend_cnt  output  W+1  number of bits set in the pending register.
REQ-012 ovf_o  output  1  sticky flag: a request arrived for a line that was already pending.

Function
REQ-013 The block SHALL hold an N-bit pending register P and a one-entry output stage {out_valid, out_idx}.
REQ-014 Each edge, P SHALL be updated as P_next = (P & ~load_mask) | req_i.
- load_mask is the one-hot of the index loaded into the output stage in the same cycle, or 0 if none.
- If a line is served and re-requested in the same cycle, the request wins: the bit stays set.
REQ-015 The output stage SHALL load when out_valid==0 or (out_valid && out_ready), provided P != 0.
- The loaded index is the priority pick from the registered P, as selected by MSB_FIRST.
REQ-016 If the output stage may load and P==0, out_valid SHALL go low on the next edge.
REQ-017 While out_valid && !out_ready, out_idx and out_valid SHALL hold stable; newer higher-priority requests SHALL NOT replace the held index.
REQ-018 Latency: a req_i pulse in cycle t with the pipe empty SHALL give out_valid=1 with that index after the edge ending cycle t+1 (two edges).
REQ-019 Throughput: with out_ready held high, one index SHALL be issued per cycle until P is empty.
REQ-020 ovf_o SHALL set when req_i[k]=1 while P[k]=1 and bit k is not being loaded in that cycle.
- ovf_o stays set until clear_i or reset.
- The duplicate request is absorbed, not counted.
REQ-021 pend_cnt SHALL equal popcount(P) as registered; it does not include the index held in the output stage.
REQ-022 clear_i SHALL take priority over all other updates on that edge: P=0, out_valid=0, out_idx=0, ovf_o=0, and req_i in that cycle is discarded.
REQ-023 The output state machine SHALL have two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- EMPTY->FULL when P!=0.
- FULL->EMPTY when accepted and P==0.
- FULL->FULL when accepted and P!=0 (reload), or when not accepted (hold).

Reset
REQ-024 On rst high, independent of clk, the block SHALL asynchronously set P=0, out_valid=0, out_idx=0, ovf_o=0 and pend_cnt=0.
REQ-025 Reset asserted mid-transfer SHALL discard pending and in-flight indices; no index SHALL be issued after release until a new req_i arrives.
REQ-026 The first edge after rst deasserts SHALL behave as a normal cycle.

Structure
REQ-027 A shared package SHALL hold the W derivation function (clog2 with minimum 1) and the state encoding constants EMPTY=0 and FULL=1.
REQ-028 The priority pick SHALL be a combinational sub-module prio_pick, parametrised on N and MSB_FIRST, with outputs index, one-hot mask and any-valid.
REQ-029 The top level SHALL contain the P register, the output stage, the overflow flag and the popcount.

Verification
REQ-030 Reset (N=8, MSB_FIRST=1): assert rst mid-simulation with no clk edge -> out_valid=0, out_idx=0, pend_cnt=0 and ovf_o=0 immediately.
REQ-031 Burst drain (N=8, MSB_FIRST=1): req_i=8'b1000_0001 for one cycle with out_ready=1 -> out_idx=7 then 0 on consecutive cycles, then out_valid=0; pend_cnt goes 2,1,0.
REQ-032 Backpressure (N=8, MSB_FIRST=1): req_i=8'b0000_0100 with out_ready=0 -> out_idx=2 held. Then req_i=8'b0100_0000 -> out_idx stays 2 until out_ready=1, then becomes 6.
REQ-033 Overflow and flush (N=8, MSB_FIRST=1): req_i[3] pulsed twice while line 3 is pending and out_ready=0 -> ovf_o=1 and pend_cnt=1. Then clear_i -> P=0, out_valid=0, ovf_o=0.
REQ-034 Serve and re-request: with out_ready=1, re-assert req_i[5] in the same cycle index 5 is loaded -> 5 is issued twice and ovf_o stays 0.
REQ-035 Alternate parameters (N=16, MSB_FIRST=0): req_i=16'h8001 -> out_idx=0 then 15, with out_idx width 4 and pend_cnt width 5.
